// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU control codes, MIPS opcode/funct values, issue FSM states and decoded-op record.
package alu_issue_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_MULT = 4'd8;
    localparam logic [3:0] ALU_DIV  = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       src_shamt;
        logic       src_imm;
        logic       ext_sign;
        logic       dest_rd;
        logic       we;
        logic       hilo;
        logic       hilo_hi;
        logic       illegal;
        logic       ovf_chk;
        logic       is_div;
    } dec_t;
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational opcode/funct to decoded-op record.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);
    always_comb begin
        dec = '0;
        dec.we = 1'b1;
        if (opcode == OP_RTYPE) begin
            dec.dest_rd = 1'b1;
            case (funct)
                FN_ADD:  dec.ovf_chk = 1'b1;
                FN_ADDU: dec.alu_control = ALU_ADD;
                FN_SUB:  begin dec.alu_control = ALU_SUB; dec.ovf_chk = 1'b1; end
                FN_SUBU: dec.alu_control = ALU_SUB;
                FN_AND:  dec.alu_control = ALU_AND;
                FN_OR:   dec.alu_control = ALU_OR;
                FN_NOR:  dec.alu_control = ALU_NOR;
                FN_SLT:  dec.alu_control = ALU_SLT;
                FN_SLL:  begin dec.alu_control = ALU_SLL; dec.src_shamt = 1'b1; end
                FN_SRL:  begin dec.alu_control = ALU_SRL; dec.src_shamt = 1'b1; end
                FN_MULT: begin dec.alu_control = ALU_MULT; dec.we = 1'b0; end
                FN_DIV:  begin dec.alu_control = ALU_DIV; dec.we = 1'b0; dec.is_div = 1'b1; end
                FN_MFHI: begin dec.hilo = 1'b1; dec.hilo_hi = 1'b1; end
                FN_MFLO: dec.hilo = 1'b1;
                default: begin dec.illegal = 1'b1; dec.we = 1'b0; end
            endcase
        end else begin
            dec.src_imm = 1'b1;
            case (opcode)
                OP_ADDI:  begin dec.ext_sign = 1'b1; dec.ovf_chk = 1'b1; end
                OP_ADDIU: dec.ext_sign = 1'b1;
                OP_SLTI:  begin dec.alu_control = ALU_SLT; dec.ext_sign = 1'b1; end
                OP_ANDI:  dec.alu_control = ALU_AND;
                OP_ORI:   dec.alu_control = ALU_OR;
                OP_BEQ:   begin dec.alu_control = ALU_SUB; dec.src_imm = 1'b0; dec.we = 1'b0; end
                default:  begin dec.illegal = 1'b1; dec.we = 1'b0; dec.src_imm = 1'b0; end
            endcase
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/retire stage in front of the MIPS ALU, producing a write-back record.
// Define ALU_ISSUE_SIGNED_OVF_EN to flag true two's-complement overflow instead of ALU carry/borrow.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_opcode,
    input  logic [5:0]            in_funct,
    input  logic [4:0]            in_shamt,
    input  logic [15:0]           in_imm,
    input  logic [DATA_W-1:0]     in_rs_val,
    input  logic [DATA_W-1:0]     in_rt_val,
    input  logic [REG_ADDR_W-1:0] in_rt_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    output logic                  alu_en,
    output logic [3:0]            alu_control,
    output logic [DATA_W-1:0]     alu_srcA,
    output logic [DATA_W-1:0]     alu_srcB,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     alu_hi,
    input  logic [DATA_W-1:0]     alu_lo,
    input  logic                  alu_overflow,
    input  logic                  alu_done,
    input  logic                  alu_zero,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_zero,
    output logic                  exc_overflow,
    output logic                  exc_divzero,
    output logic                  exc_illegal
);
    state_t state, state_nxt;
    dec_t dec;
    logic armed, accept, resp, ovf_raw;
    logic op_we, op_ovf, op_div, op_ill;
    logic zero_q, ovf_q;
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0] res, imm_ext;

    alu_issue_decode u_dec (.opcode(in_opcode), .funct(in_funct), .dec(dec));

    assign imm_ext = dec.ext_sign ? {{(DATA_W-16){in_imm[15]}}, in_imm} : {{(DATA_W-16){1'b0}}, in_imm};
    assign accept  = in_ready && in_valid;

    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? ((dec.hilo || dec.illegal) ? RESP : EXEC) : IDLE;
            EXEC:    state_nxt = WAIT;
            WAIT:    state_nxt = alu_done ? RESP : WAIT;
            RESP:    state_nxt = wb_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // armed holds in_ready low for the first cycle after reset is released
    always_ff @(posedge clk) begin
        if (rst) begin
            armed       <= 1'b0;
            alu_control <= '0;
            alu_srcA    <= '0;
            alu_srcB    <= '0;
            dst         <= '0;
            res         <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            op_we       <= 1'b0;
            op_ovf      <= 1'b0;
            op_div      <= 1'b0;
            op_ill      <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                alu_control <= dec.alu_control;
                alu_srcA    <= dec.src_shamt ? {{(DATA_W-5){1'b0}}, in_shamt} : in_rs_val;
                alu_srcB    <= dec.src_imm ? imm_ext : in_rt_val;
                dst         <= dec.dest_rd ? in_rd_addr : in_rt_addr;
                res         <= dec.hilo_hi ? alu_hi : alu_lo;
                zero_q      <= 1'b0;
                ovf_q       <= 1'b0;
                op_we       <= dec.we;
                op_ovf      <= dec.ovf_chk;
                op_div      <= dec.is_div;
                op_ill      <= dec.illegal;
            end else if (state == WAIT && alu_done) begin
                res    <= alu_result;
                zero_q <= alu_zero;
                ovf_q  <= alu_overflow;
            end
        end
    end

`ifdef ALU_ISSUE_SIGNED_OVF_EN
    assign ovf_raw = (alu_control == ALU_SUB)
        ? (alu_srcA[DATA_W-1] != alu_srcB[DATA_W-1]) && (res[DATA_W-1] != alu_srcA[DATA_W-1])
        : (alu_srcA[DATA_W-1] == alu_srcB[DATA_W-1]) && (res[DATA_W-1] != alu_srcA[DATA_W-1]);
`else
    assign ovf_raw = ovf_q;
`endif

    always_comb begin
        resp         = state == RESP;
        in_ready     = state == IDLE && armed;
        alu_en       = state == EXEC;
        wb_valid     = resp;
        exc_overflow = resp && op_ovf && ovf_raw;
        exc_divzero  = resp && op_div && ovf_q;
        exc_illegal  = resp && op_ill;
        wb_we        = resp && op_we && (dst != '0) && !exc_overflow;
        wb_addr      = resp ? dst : '0;
        wb_data      = resp ? res : '0;
        wb_zero      = resp && zero_q;
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of alu_issue_ctrl against a small behavioural ALU.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, in_valid = 1'b0, in_ready, wb_ready = 1'b1;
    logic [5:0]  in_opcode = '0, in_funct = '0;
    logic [4:0]  in_shamt = '0, in_rt_addr = '0, in_rd_addr = '0;
    logic [15:0] in_imm = '0;
    logic [31:0] in_rs_val = '0, in_rt_val = '0;
    logic        alu_en, alu_overflow = 1'b0, alu_done = 1'b0, alu_zero;
    logic [3:0]  alu_control;
    logic [31:0] alu_srcA, alu_srcB, alu_result = '0, alu_hi = '0, alu_lo = '0;
    logic        wb_valid, wb_we, wb_zero, exc_overflow, exc_divzero, exc_illegal;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

`ifdef ALU_ISSUE_SIGNED_OVF_EN
    localparam bit SOVF = 1'b1;
`else
    localparam bit SOVF = 1'b0;
`endif

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
        .alu_en(alu_en), .alu_control(alu_control), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
        .alu_result(alu_result), .alu_hi(alu_hi), .alu_lo(alu_lo), .alu_overflow(alu_overflow),
        .alu_done(alu_done), .alu_zero(alu_zero), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_zero(wb_zero),
        .exc_overflow(exc_overflow), .exc_divzero(exc_divzero), .exc_illegal(exc_illegal)
    );

    // behavioural ALU: one-cycle latency, done sticks high, carry/borrow/div-by-zero on overflow
    assign alu_zero = alu_result == 32'd0;
    always @(posedge clk) begin
        if (alu_en) begin
            alu_done     <= 1'b1;
            alu_overflow <= 1'b0;
            case (alu_control)
                4'd0: {alu_overflow, alu_result} <= {1'b0, alu_srcA} + {1'b0, alu_srcB};
                4'd1: begin alu_result <= alu_srcA - alu_srcB; alu_overflow <= alu_srcA < alu_srcB; end
                4'd2: alu_result <= alu_srcA & alu_srcB;
                4'd3: alu_result <= alu_srcA | alu_srcB;
                4'd4: alu_result <= ~(alu_srcA | alu_srcB);
                4'd5: alu_result <= {31'b0, alu_srcA < alu_srcB};
                4'd6: alu_result <= alu_srcB << alu_srcA[4:0];
                4'd7: alu_result <= alu_srcB >> alu_srcA[4:0];
                4'd8: {alu_hi, alu_lo} <= {32'b0, alu_srcA} * {32'b0, alu_srcB};
                4'd9: begin
                    if (alu_srcB == 32'd0) alu_overflow <= 1'b1;
                    else begin alu_lo <= alu_srcA / alu_srcB; alu_hi <= alu_srcA % alu_srcB; end
                end
                default: alu_result <= 32'd0;
            endcase
        end
    end

    int checks = 0, errors = 0;
    int lat, pulses, pcyc;
    logic [31:0] sa, sb;
    logic [3:0]  sc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] rta, input logic [4:0] rda);
        chk("in_ready_before_issue", in_ready, 1);
        in_valid = 1'b1; in_opcode = opc; in_funct = fn; in_shamt = sh; in_imm = imm;
        in_rs_val = rs; in_rt_val = rt; in_rt_addr = rta; in_rd_addr = rda;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; pulses = 0; pcyc = 0;
        while (!wb_valid && lat < 20) begin
            if (alu_en) begin pulses++; pcyc = lat; sa = alu_srcA; sb = alu_srcB; sc = alu_control; end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_alu_control", alu_control, 0);
        chk("rst_srcA", alu_srcA, 0);
        chk("rst_srcB", alu_srcB, 0);
        rst = 1'b0;
        chk("ready_low_first_cycle", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_high_after_rst", in_ready, 1);

        issue(6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, 5'd0, 5'd3);
        chk("add_lat", lat, 3);
        chk("add_pulses", pulses, 1);
        chk("add_pulse_cycle", pcyc, 1);
        chk("add_srcA", sa, 5);
        chk("add_srcB", sb, 7);
        chk("add_ctl", sc, 0);
        chk("add_addr", wb_addr, 3);
        chk("add_data", wb_data, 12);
        chk("add_we", wb_we, 1);
        chk("add_in_ready_resp", in_ready, 0);
        retire();

        issue(6'h00, 6'h00, 5'd4, 16'h0, 32'h55, 32'h1, 5'd0, 5'd2);
        chk("sll_srcA", sa, 4);
        chk("sll_srcB", sb, 1);
        chk("sll_ctl", sc, 6);
        chk("sll_data", wb_data, 32'h10);
        chk("sll_addr", wb_addr, 2);
        retire();

        issue(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'hFFFFFFFF, 32'h0, 5'd9, 5'd0);
        chk("addi_srcB", sb, 32'hFFFFFFFF);
        chk("addi_addr", wb_addr, 9);
        chk("addi_data", wb_data, 32'hFFFFFFFE);
        chk("addi_ovf", exc_overflow, SOVF ? 0 : 1);
        chk("addi_we", wb_we, SOVF ? 1 : 0);
        retire();

        issue(6'h0C, 6'h00, 5'd0, 16'h8001, 32'hFFFFFFFF, 32'h0, 5'd5, 5'd0);
        chk("andi_srcB", sb, 32'h00008001);
        chk("andi_data", wb_data, 32'h00008001);
        retire();

        issue(6'h00, 6'h2A, 5'd0, 16'h0, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd6);
        chk("slt_unsigned_data", wb_data, 0);
        retire();

        issue(6'h00, 6'h18, 5'd0, 16'h0, 32'h10000, 32'h10000, 5'd0, 5'd7);
        chk("mult_ctl", sc, 8);
        chk("mult_we", wb_we, 0);
        retire();
        issue(6'h00, 6'h10, 5'd0, 16'h0, 32'h0, 32'h0, 5'd0, 5'd4);
        chk("mfhi_lat", lat, 1);
        chk("mfhi_pulses", pulses, 0);
        chk("mfhi_data", wb_data, 1);
        chk("mfhi_addr", wb_addr, 4);
        chk("mfhi_we", wb_we, 1);
        retire();

        issue(6'h00, 6'h1A, 5'd0, 16'h0, 32'd100, 32'd0, 5'd0, 5'd8);
        chk("div_ctl", sc, 9);
        chk("div_divzero", exc_divzero, 1);
        chk("div_ovf", exc_overflow, 0);
        chk("div_we", wb_we, 0);
        retire();
        issue(6'h04, 6'h00, 5'd0, 16'h10, 32'd6, 32'd6, 5'd6, 5'd0);
        chk("beq_ctl", sc, 1);
        chk("beq_srcB", sb, 6);
        chk("beq_zero", wb_zero, 1);
        chk("beq_we", wb_we, 0);
        retire();

        issue(6'h3F, 6'h00, 5'd0, 16'h0, 32'd1, 32'd1, 5'd1, 5'd1);
        chk("ill_lat", lat, 1);
        chk("ill_pulses", pulses, 0);
        chk("ill_flag", exc_illegal, 1);
        chk("ill_we", wb_we, 0);
        retire();

        issue(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd1, 5'd0, 5'd0);
        chk("r0_data", wb_data, 2);
        chk("r0_we", wb_we, 0);
        retire();

        issue(6'h00, 6'h20, 5'd0, 16'h0, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd3);
        chk("add_max_ovf", exc_overflow, SOVF ? 1 : 0);
        chk("add_max_we", wb_we, SOVF ? 0 : 1);
        chk("add_max_data", wb_data, 32'h80000000);
        retire();
        issue(6'h00, 6'h21, 5'd0, 16'h0, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd3);
        chk("addu_max_ovf", exc_overflow, 0);
        chk("addu_max_we", wb_we, 1);
        retire();
        issue(6'h00, 6'h22, 5'd0, 16'h0, 32'd1, 32'd2, 5'd0, 5'd3);
        chk("sub_borrow_ovf", exc_overflow, SOVF ? 0 : 1);
        chk("sub_borrow_data", wb_data, 32'hFFFFFFFF);
        retire();
        issue(6'h00, 6'h23, 5'd0, 16'h0, 32'd1, 32'd2, 5'd0, 5'd3);
        chk("subu_borrow_ovf", exc_overflow, 0);
        retire();

        wb_ready = 1'b0;
        issue(6'h00, 6'h20, 5'd0, 16'h0, 32'd2, 32'd3, 5'd0, 5'd5);
        chk("stall_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", wb_valid, 1);
            chk("stall_data", wb_data, 5);
            chk("stall_addr", wb_addr, 5);
            chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        retire();
        chk("stall_release_valid", wb_valid, 0);
        chk("stall_release_ready", in_ready, 1);

        in_valid = 1'b1; in_opcode = 6'h00; in_funct = 6'h25;
        in_rs_val = 32'hF0; in_rt_val = 32'h0F; in_rd_addr = 5'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort_exec_en", alu_en, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_alu_en", alu_en, 0);
        chk("abort_ctl", alu_control, 0);
        chk("abort_srcA", alu_srcA, 0);
        chk("abort_srcB", alu_srcB, 0);
        chk("abort_wb_valid", wb_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_wb", wb_valid, 0);
        end

        issue(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd1, 5'd0, 5'd1);
        chk("recover_lat", lat, 3);
        chk("recover_data", wb_data, 2);
        retire();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
